serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial WIDTH-bit adder built around one FA1bit cell: it loads two operands and a carry-in,
//  feeds the cell one bit pair per clock (LSB first) and registers the carry between cycles.
//  It assembles the sum bits into a parallel result and signals completion with a start/busy/done handshake.
//  It drives the FA1bit cell directly and presents a parallel-adder-like interface to the datapath above it.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  start     in   1      request; sampled on rising edge, accepted only in IDLE or DONE
//  a_in      in   WIDTH  operand A, captured on accepted start
//  b_in      in   WIDTH  operand B, captured on accepted start
//  cin_in    in   1      carry-in, captured on accepted start
//  busy      out  1      high while in SHIFT
//  done      out  1      one-cycle pulse: result valid
//  sum_out   out  WIDTH  registered sum, held until next completion
//  cout_out  out  1      registered carry-out, held until next completion
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; busy, done, sum_out, cout_out, shift regs, carry, count all 0.
//  - FSM states IDLE, SHIFT, DONE:
//      IDLE  --start--> SHIFT
//      SHIFT --count==WIDTH-1--> DONE
//      DONE  --start--> SHIFT, else --> IDLE
//  - Accept edge: a_sr<=a_in; b_sr<=b_in; carry<=cin_in; count<=0; s_sr<=0.
//  - Each SHIFT edge: FA1bit(cin=carry, a=a_sr[0], b=b_sr[0]) -> carry<=cout;
//    s_sr<={sum, s_sr[WIDTH-1:1]}; a_sr, b_sr shift right by 1 (MSB fill 0); count<=count+1.
//  - Final SHIFT edge (count==WIDTH-1): sum_out<={sum, s_sr[WIDTH-1:1]}; cout_out<=cout.
//  - Latency: start sampled at edge N -> WIDTH SHIFT edges N+1..N+WIDTH -> done high for the cycle after edge N+WIDTH.
//    Throughput: one add per WIDTH+1 cycles (back-to-back start accepted in DONE).
//  - busy = (state==SHIFT); done = (state==DONE); both decoded from registered state (glitch-free).
//  - start while busy: ignored, no queuing; operands of the running add are unaffected.
//  - sum_out/cout_out change only on a final SHIFT edge; never show partial results.
//  - Arithmetic: {cout_out,sum_out} == a_in + b_in + cin_in, (WIDTH+1)-bit, unsigned; no overflow flag.
//  - count width = $clog2(WIDTH); saturation is not possible (exits at WIDTH-1).
//  - Reset mid-operation: add aborted, no done pulse, previous result cleared to 0.
//  - X on start while rst_n=0 is don't-care.
// STRUCTURE
//  - Shared include serial_adder_pkg.vh: state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2,
//    count-width helper; used by RTL and bench.
//  - One sub-module: FA1bit (port order cin, a, b, sum, cout), instantiated once, combinational.
//  - Top holds FSM, counter, carry flop, three shift regs, result regs.
// TESTING (WIDTH=8 unless noted)
//  1. a=8'hFF, b=8'h01, cin=0, start 1 cycle -> done pulse 9 edges after start; sum_out=8'h00, cout_out=1.
//  2. a=8'h5A, b=8'h33, cin=1 -> sum_out=8'h8E, cout_out=0; busy high exactly 8 cycles.
//  3. Start 8'h10+8'h20, re-assert start with 8'hFF+8'hFF at shift 3 -> ignored; result 8'h30, cout 0.
//  4. Hold start high through DONE: 8'h01+8'h01 then 8'h80+8'h80 -> 8'h02/0, then 8'h00/1;
//     second done exactly 9 cycles after the first.
//  5. Complete 8'hAA+8'h55 (8'hFF), then new add; drop rst_n at shift 4 -> busy, done, sum_out, cout_out
//     all 0 immediately; no done pulse after release.
//  6. WIDTH=3 exhaustive: all 128 {cin,a,b} combinations -> {cout_out,sum_out}==a+b+cin; $stop on mismatch.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encodings and the helper that sizes the bit counter.
package serial_adder_ctrl_pkg;

   // FSM state encodings, kept as plain constants so older tools and
   // benches can compare against raw 2-bit values.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Bit counter width: enough to hold 0..width-1, never narrower than 1.
   function automatic int count_width(input int width);
      int w;
      w = $clog2(width);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa1bit.sv
// One-bit full adder cell used by the serial adder, purely combinational.
module FA1bit (
   input  logic cin,
   input  logic a,
   input  logic b,
   output logic sum,
   output logic cout
);

   // Classic sum/majority equations for a single bit position.
   always_comb begin
      sum  = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: captures two operands and a carry-in on an
// accepted start, adds one bit pair per clock through a single FA1bit cell
// (LSB first) and publishes the parallel sum with a one-cycle done pulse.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out
);

   localparam int             CW   = count_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_sr;
   logic             carry;
   logic [CW-1:0]    count;
   logic             fa_sum;
   logic             fa_cout;
   logic             accept;
   logic             last_bit;

   // A new add is only taken when nothing is running; start during SHIFT
   // is simply dropped so the running operands stay intact.
   assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign last_bit = (state == ST_SHIFT) && (count == LAST);

   // Status flags decoded straight from the state register so they never glitch.
   assign busy = (state == ST_SHIFT);
   assign done = (state == ST_DONE);

   FA1bit u_fa (
      .cin  (carry),
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Next-state logic: run WIDTH shift cycles, then present DONE for one cycle.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (last_bit) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (accept) begin
               state_next = ST_SHIFT;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Operand/sum shift registers, carry flop and bit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         s_sr  <= '0;
         carry <= 1'b0;
         count <= '0;
      end else if (accept) begin
         a_sr  <= a_in;
         b_sr  <= b_in;
         s_sr  <= '0;
         carry <= cin_in;
         count <= '0;
      end else if (state == ST_SHIFT) begin
         a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
         s_sr  <= {fa_sum, s_sr[WIDTH-1:1]};
         carry <= fa_cout;
         count <= count + 1'b1;
      end
   end

   // Result registers only move on the final bit, so partial sums never show.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_out  <= '0;
         cout_out <= 1'b0;
      end else if (last_bit) begin
         sum_out  <= {fa_sum, s_sr[WIDTH-1:1]};
         cout_out <= fa_cout;
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: the driver pushes the expected
// result and acceptance edge for every add, monitors pop on each done pulse.
module tb_serial_adder_ctrl;

   typedef struct {
      logic [8:0] res;
      int         edge_no;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       cin_in;
   logic       busy;
   logic       done;
   logic [7:0] sum_out;
   logic       cout_out;

   logic       start3;
   logic [2:0] a3;
   logic [2:0] b3;
   logic       cin3;
   logic       busy3;
   logic       done3;
   logic [2:0] sum3;
   logic       cout3;

   int         tests_run;
   int         tests_failed;
   int         edge_cnt;
   exp_t       q[$];
   logic [3:0] q3[$];

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a_in     (a_in),
      .b_in     (b_in),
      .cin_in   (cin_in),
      .busy     (busy),
      .done     (done),
      .sum_out  (sum_out),
      .cout_out (cout_out)
   );

   serial_adder_ctrl #(.WIDTH(3)) dut3 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start3),
      .a_in     (a3),
      .b_in     (b3),
      .cin_in   (cin3),
      .busy     (busy3),
      .done     (done3),
      .sum_out  (sum3),
      .cout_out (cout3)
   );

   // Free-running clock and an edge counter used for latency checks.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one 8-bit add with a one-cycle start pulse and queue its expectation.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                                input logic [8:0] exp_res);
      exp_t e;
      @(negedge clk);
      start  = 1'b1;
      a_in   = a;
      b_in   = b;
      cin_in = c;
      e.res     = exp_res;
      e.edge_no = edge_cnt + 1;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Bounded wait for the scoreboard to empty, then one idle cycle.
   task automatic waitDrain(input int budget);
      int k;
      k = 0;
      while ((q.size() != 0) && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      checkOutput("drain", q.size(), 0);
      @(negedge clk);
   endtask

   // Monitor for the 8-bit instance: result, latency, busy length, pulse width.
   initial begin
      int   busy_run;
      logic prev_done;
      exp_t e;
      busy_run  = 0;
      prev_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            busy_run  = 0;
            prev_done = 1'b0;
         end else begin
            if (busy) busy_run++;
            if (done) begin
               checkOutput("done_single_cycle", {31'd0, prev_done}, 0);
               if (q.size() == 0) begin
                  checkOutput("unexpected_done", 1, 0);
               end else begin
                  e = q.pop_front();
                  checkOutput("result", {23'd0, cout_out, sum_out}, {23'd0, e.res});
                  checkOutput("done_latency", edge_cnt, e.edge_no + 8);
                  checkOutput("busy_cycles", busy_run, 8);
               end
               busy_run = 0;
            end
            prev_done = done;
         end
      end
   end

   // Monitor for the 3-bit instance.
   initial begin
      logic [3:0] e3;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && done3) begin
            if (q3.size() == 0) begin
               checkOutput("unexpected_done3", 1, 0);
            end else begin
               e3 = q3.pop_front();
               checkOutput("result_w3", {28'd0, cout3, sum3}, {28'd0, e3});
            end
         end
      end
   end

   // Directed test sequence.
   initial begin
      exp_t e;
      int   n;
      tests_run    = 0;
      tests_failed = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      a_in   = '0;
      b_in   = '0;
      cin_in = 1'b0;
      start3 = 1'b0;
      a3     = '0;
      b3     = '0;
      cin3   = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("reset_busy", {31'd0, busy}, 0);
      checkOutput("reset_done", {31'd0, done}, 0);
      checkOutput("reset_sum", {24'd0, sum_out}, 0);
      checkOutput("reset_cout", {31'd0, cout_out}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: carry ripples through every bit
      applyStimulus(8'hFF, 8'h01, 1'b0, 9'h100);
      waitDrain(20);

      // 2: carry-in used
      applyStimulus(8'h5A, 8'h33, 1'b1, 9'h08E);
      waitDrain(20);

      // 3: start during SHIFT is ignored, result held meanwhile
      applyStimulus(8'h10, 8'h20, 1'b0, 9'h030);
      repeat (3) @(negedge clk);
      start = 1'b1;
      a_in  = 8'hFF;
      b_in  = 8'hFF;
      checkOutput("held_sum", {24'd0, sum_out}, 32'h8E);
      checkOutput("held_cout", {31'd0, cout_out}, 0);
      checkOutput("busy_mid_add", {31'd0, busy}, 1);
      @(negedge clk);
      start = 1'b0;
      waitDrain(20);

      // 4: start held through DONE gives a back-to-back add
      @(negedge clk);
      start  = 1'b1;
      a_in   = 8'h01;
      b_in   = 8'h01;
      cin_in = 1'b0;
      n = edge_cnt + 1;
      e.res = 9'h002;
      e.edge_no = n;
      q.push_back(e);
      @(negedge clk);
      a_in = 8'h80;
      b_in = 8'h80;
      e.res = 9'h100;
      e.edge_no = n + 9;
      q.push_back(e);
      repeat (9) @(negedge clk);
      start = 1'b0;
      waitDrain(30);

      // 5: reset in the middle of an add aborts it and clears the result
      applyStimulus(8'hAA, 8'h55, 1'b0, 9'h0FF);
      waitDrain(20);
      applyStimulus(8'h12, 8'h34, 1'b0, 9'h046);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      void'(q.pop_back());
      #1;
      checkOutput("abort_busy", {31'd0, busy}, 0);
      checkOutput("abort_done", {31'd0, done}, 0);
      checkOutput("abort_sum", {24'd0, sum_out}, 0);
      checkOutput("abort_cout", {31'd0, cout_out}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      checkOutput("no_done_after_abort", {24'd0, sum_out}, 0);
      checkOutput("queue_empty", q.size(), 0);

      // 6: WIDTH=3 exhaustive over {cin,a,b}
      for (int i = 0; i < 128; i++) begin
         logic [6:0] v;
         v = 7'(i);
         @(negedge clk);
         start3 = 1'b1;
         cin3   = v[6];
         a3     = v[5:3];
         b3     = v[2:0];
         q3.push_back(4'(v[5:3]) + 4'(v[2:0]) + 4'(v[6]));
         @(negedge clk);
         start3 = 1'b0;
         repeat (4) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      checkOutput("queue3_empty", q3.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
